// File: rtl/gpout_console_tx.sv
// -----------------------------------------------------------------------------
// gpout_console_tx
//
// Transmitter for the GPOUT debug console. Firmware or the bus bridge pushes
// 8-bit items, each tagged as a character or a numeric code, into a small
// FIFO. A sequencer pops one item at a time and serialises it onto GPOUT as a
// data-plus-strobe transfer:
//   - GPOUT[7:0] carries the item payload, loaded on the pop edge.
//   - GPOUT[9] pulses for characters and GPOUT[10] pulses for codes.
//   - GPOUT[8] mirrors BUSY.
//   - GPOUT[15:11] are tied low.
// Each transfer has three phases: setup (data stable, strobe low), strobe
// (strobe high) and hold (strobe low, data still stable).
// Transmitting code 8'd1 halts the block until reset. The FIFO keeps
// accepting items after the halt, but they are never sent.
//
// Ports
//   CLK      in   system clock
//   RSTn     in   asynchronous active-low reset
//   WR_EN    in   push request (one item per cycle)
//   WR_DATA  in   [7:0] item payload
//   WR_KIND  in   0 = character, 1 = code
//   FULL     out  FIFO holds FIFO_DEPTH items (registered)
//   EMPTY    out  FIFO holds no items (registered)
//   BUSY     out  sequencer is not idle (registered)
//   OVF      out  sticky: a push was dropped because the FIFO was full
//   DONE     out  code 8'd1 has been sent; block halted
//   GPOUT    out  [15:0] console pins, all bits registered
//
// Push handshake: WR_EN acts as a valid with no back-pressure. The matching
// "ready" is !FULL as registered at the start of the cycle. An item offered
// while FULL=1 is dropped and OVF sets. A pop in that same cycle does not
// rescue the item.
// -----------------------------------------------------------------------------
module gpout_console_tx #(
  parameter int FIFO_DEPTH    = 16,  // power of two, >= 2
  parameter int SETUP_CYCLES  = 1,   // >= 1
  parameter int STROBE_CYCLES = 2,   // >= 1
  parameter int HOLD_CYCLES   = 1    // >= 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        WR_EN,
  input  logic [7:0]  WR_DATA,
  input  logic        WR_KIND,
  output logic        FULL,
  output logic        EMPTY,
  output logic        BUSY,
  output logic        OVF,
  output logic        DONE,
  output logic [15:0] GPOUT
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);  // pointer width
  localparam int CW = AW + 1;              // count width, holds 0..FIFO_DEPTH

  localparam int MAX_SS  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
  // The phase timer counts down from (cycles-1) to 0, so it only has to
  // represent MAX_CYC-1.
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);
  localparam logic [TW-1:0] TMR_SETUP  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMR_STROBE = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_HOLD   = TW'(HOLD_CYCLES - 1);

  localparam logic [7:0] HALT_CODE = 8'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  // FIFO storage and control. Each entry is {KIND, DATA}.
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          empty_q;
  logic          ovf_q;

  // Sequencer state and registered outputs.
  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    data_q;
  logic          kind_q;
  logic          chr_stb_q;
  logic          code_stb_q;
  logic          busy_q;
  logic          done_q;

  logic          push_ok;
  logic          pop;
  logic [8:0]    rd_item;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign push_ok = WR_EN & ~full_q;
  // Items are only popped from IDLE. DONE also blocks popping, so HALT is
  // terminal even though the FIFO keeps filling.
  assign pop     = (state_q == S_IDLE) & ~empty_q & ~done_q;
  assign rd_item = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;  // idle, or push and pop cancel out
    endcase
  end

  // Payload storage needs no reset: an entry is only read after a push has
  // written it.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {WR_KIND, WR_DATA};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == COUNT_FULL);
      empty_q <= (count_d == '0);
      if (WR_EN && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // Every GPOUT bit comes from a flop written here, so the pins never glitch.
  // The data byte is only written on the pop edge. That keeps it stable
  // through setup, strobe and hold by construction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      data_q     <= '0;
      kind_q     <= 1'b0;
      chr_stb_q  <= 1'b0;
      code_stb_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            data_q  <= rd_item[7:0];
            kind_q  <= rd_item[8];
            timer_q <= TMR_SETUP;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (timer_q == '0) begin
            // Exactly one strobe, chosen by the popped kind.
            chr_stb_q  <= ~kind_q;
            code_stb_q <= kind_q;
            timer_q    <= TMR_STROBE;
            state_q    <= S_STROBE;
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end

        S_STROBE: begin
          if (timer_q == '0) begin
            chr_stb_q  <= 1'b0;
            code_stb_q <= 1'b0;
            timer_q    <= TMR_HOLD;
            state_q    <= S_HOLD;
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end

        S_HOLD: begin
          if (timer_q == '0) begin
            if (kind_q && (data_q == HALT_CODE)) begin
              // BUSY stays high in HALT because the FSM is not in IDLE.
              done_q  <= 1'b1;
              state_q <= S_HALT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end

        S_HALT: begin
          state_q <= S_HALT;
        end

        default: begin
          state_q    <= S_IDLE;
          chr_stb_q  <= 1'b0;
          code_stb_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign FULL  = full_q;
  assign EMPTY = empty_q;
  assign BUSY  = busy_q;
  assign OVF   = ovf_q;
  assign DONE  = done_q;
  assign GPOUT = {5'b0_0000, code_stb_q, chr_stb_q, busy_q, data_q};

endmodule

// File: tb/tb_gpout_console_tx.sv
// -----------------------------------------------------------------------------
// tb_gpout_console_tx
//
// Bench for gpout_console_tx. A behavioural model tracks the FIFO as a queue.
// It treats the transmitter as a resource that takes one item every PERIOD
// cycles. On each pop the model predicts the strobe (cycle, kind, data) and
// pushes it into exp_q. A separate monitor watches GPOUT and pops exp_q on
// every strobe rising edge. Every cycle it also compares the flags and the
// data byte against the model.
// -----------------------------------------------------------------------------
module tb_gpout_console_tx;

  localparam int DEPTH  = 16;
  localparam int SETUP  = 1;
  localparam int STRB   = 2;
  localparam int HOLD   = 1;
  localparam int PERIOD = 1 + SETUP + STRB + HOLD;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_kind;
  logic        full;
  logic        empty;
  logic        busy;
  logic        ovf;
  logic        done;
  logic [15:0] gpout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gpout_console_tx #(
    .FIFO_DEPTH   (DEPTH),
    .SETUP_CYCLES (SETUP),
    .STROBE_CYCLES(STRB),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .CLK    (clk),
    .RSTn   (rst_n),
    .WR_EN  (wr_en),
    .WR_DATA(wr_data),
    .WR_KIND(wr_kind),
    .FULL   (full),
    .EMPTY  (empty),
    .BUSY   (busy),
    .OVF    (ovf),
    .DONE   (done),
    .GPOUT  (gpout)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [8:0]  m_q[$];        // queued {kind, data}
  logic [40:0] exp_q[$];      // {strobe rise cycle, kind, data}
  bit          m_ovf;
  bit          m_halting;     // the halt code has been popped
  int          m_last_pop;    // cycle of the latest pop, -1 if none
  logic [7:0]  m_data;        // byte expected on GPOUT[7:0]
  int          m_sz;
  logic [8:0]  m_item;
  bit          m_can_pop;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_ovf      = 1'b0;
    m_halting  = 1'b0;
    m_last_pop = -1;
    m_data     = 8'h00;
  endtask

  function automatic bit e_busy();
    return (m_last_pop >= 0) && (m_halting || (cyc <= m_last_pop + PERIOD - 2));
  endfunction

  function automatic bit e_done();
    return m_halting && (cyc >= m_last_pop + PERIOD - 1);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        m_sz      = m_q.size();
        m_can_pop = !m_halting && ((m_last_pop < 0) || (cyc >= m_last_pop + PERIOD));
        if (m_can_pop && (m_sz > 0)) begin
          m_item     = m_q.pop_front();
          m_last_pop = cyc;
          m_data     = m_item[7:0];
          exp_q.push_back({32'(cyc + SETUP), m_item});
          if (m_item == 9'h101) m_halting = 1'b1;
        end
        // Acceptance depends on occupancy at the start of the cycle.
        if (wr_en) begin
          if (m_sz < DEPTH) m_q.push_back({wr_kind, wr_data});
          else              m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit          prev9;
  bit          prev10;
  bit          active;
  int          width;
  logic [40:0] cur;

  initial begin
    prev9 = 0; prev10 = 0; active = 0; width = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        prev9 = 0; prev10 = 0; active = 0; width = 0;
      end else begin
        check("busy",        32'(busy),          32'(e_busy()));
        check("gpout8_busy", 32'(gpout[8]),      32'(e_busy()));
        check("done",        32'(done),          32'(e_done()));
        check("full",        32'(full),          32'(m_q.size() == DEPTH));
        check("empty",       32'(empty),         32'(m_q.size() == 0));
        check("ovf",         32'(ovf),           32'(m_ovf));
        check("data",        32'(gpout[7:0]),    32'(m_data));
        check("upper_zero",  32'(gpout[15:11]),  0);
        check("one_strobe",  32'(gpout[9] & gpout[10]), 0);
        if ((gpout[9] && !prev9) || (gpout[10] && !prev10)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got gpout %h, expected no strobe (cycle %0d)", gpout, cyc);
          end else begin
            cur = exp_q.pop_front();
            check("strobe_cycle", 32'(cyc),        cur[40:9]);
            check("strobe_kind",  32'(gpout[10]),  32'(cur[8]));
            check("strobe_data",  32'(gpout[7:0]), 32'(cur[7:0]));
          end
          active = 1;
          width  = 1;
        end else if (active && (gpout[9] || gpout[10])) begin
          width++;
        end else if (active) begin
          check("strobe_width", 32'(width), STRB);
          active = 0;
        end
        prev9  = gpout[9];
        prev10 = gpout[10];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push(input logic k, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_kind = k;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_kind = 1'b0; wr_data = 8'h00;
    idle(3);
    check("rst_gpout", 32'(gpout), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full),  0);
    check("rst_busy",  32'(busy),  0);
    check("rst_ovf",   32'(ovf),   0);
    check("rst_done",  32'(done),  0);
    rst_n = 1'b1;
    idle(5);

    // Single character.
    push(1'b0, 8'h41);
    idle(8);

    // "Hi\n" back-to-back.
    push(1'b0, 8'h48);
    push(1'b0, 8'h69);
    push(1'b0, 8'h0A);
    idle(20);

    // Random streaming faster than the drain rate: fills the FIFO, overflows,
    // and lands pushes on pop cycles while full.
    for (int i = 0; i < 300; i++) begin
      wr_en   = ($urandom_range(0, 9) < 7);
      wr_kind = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom_range(0, 255));
      if (wr_kind && (wr_data == 8'd1)) wr_data = 8'd2;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("stream_ovf", 32'(ovf), 1);
    idle(DEPTH * PERIOD + 20);
    check("stream_drained", 32'(exp_q.size()), 0);
    check("stream_empty",   32'(empty), 1);

    // Asynchronous reset while a code strobe is high with items queued.
    push(1'b1, 8'h33);
    push(1'b0, 8'h61);
    push(1'b0, 8'h62);
    push(1'b0, 8'h63);
    for (int i = 0; i < 20 && !gpout[10]; i++) @(negedge clk);
    check("code_strobe_seen", 32'(gpout[10]), 1);
    check("queued_before_rst", 32'(empty), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_gpout", 32'(gpout), 0);
    check("async_rst_empty", 32'(empty), 1);
    check("async_rst_ovf",   32'(ovf),   0);
    #2 rst_n = 1'b1;
    idle(20);
    check("post_rst_empty", 32'(empty), 1);

    // Code 42 then halt code; later pushes are stored but never sent.
    push(1'b1, 8'd42);
    push(1'b1, 8'd1);
    idle(15);
    check("halt_done", 32'(done), 1);
    check("halt_data", 32'(gpout[7:0]), 1);
    push(1'b0, 8'h5A);
    check("halt_push_empty", 32'(empty), 0);
    for (int i = 0; i < DEPTH; i++) push(1'b0, 8'(8'h30 + i));
    check("halt_full", 32'(full), 1);
    check("halt_ovf",  32'(ovf),  1);
    idle(10);
    check("halt_no_tx", 32'(exp_q.size()), 0);
    check("halt_still_done", 32'(done), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpout_console_tx.md
Name: gpout_console_tx

Overview:
- DUT-side transmitter for the GPOUT debug console protocol. The testbench display decoder is the receiver.
- Firmware or the bus bridge pushes 8-bit items into a small FIFO, each tagged as either a character or a code. The block serialises them onto GPOUT as data-plus-strobe transfers.
- GPOUT[9] rising edge prints GPOUT[7:0] as a character.
- GPOUT[10] rising edge reports GPOUT[7:0] as a numeric code; code 8'd1 ends the simulation.
- Sits between the APB/GPIO register slice and the top-level GPOUT pins.

Parameters:
FIFO_DEPTH, 16, number of queued items; must be a power of two and at least 2.
SETUP_CYCLES, 1, cycles GPOUT[7:0] is stable before the strobe rises; at least 1.
STROBE_CYCLES, 2, cycles the strobe stays high; at least 1.
HOLD_CYCLES, 1, cycles data is held after the strobe falls; at least 1.

Ports:
CLK  input  1  system clock (80 MHz)
RSTn  input  1  asynchronous active-low reset
WR_EN  input  1  push request, one item per cycle
WR_DATA  input  8  item payload
WR_KIND  input  1  0 = character (strobe GPOUT[9]), 1 = code (strobe GPOUT[10])
FULL  output  1  FIFO holds FIFO_DEPTH items
EMPTY  output  1  FIFO holds 0 items
BUSY  output  1  FSM not in IDLE
OVF  output  1  sticky: a push was dropped
DONE  output  1  code 8'd1 has been transmitted; block is halted
GPOUT  output  16  [7:0] data, [8] = BUSY, [9] char strobe, [10] code strobe, [15:11] = 0

Behaviour:
- Reset (RSTn low, asynchronous): FIFO pointers and count cleared.
  - EMPTY=1; FULL, BUSY, OVF, DONE = 0; GPOUT = 16'h0000; FSM = IDLE.
  - Reset mid-transfer drops the strobe immediately and discards all queued items.
- FIFO:
  - Entries are 9 bits {KIND, DATA}.
  - A push is accepted on a rising edge when WR_EN=1 and FULL=0 (FULL as registered at the start of that cycle).
  - If WR_EN=1 while FULL=1: the item is dropped and OVF sets, even if a pop occurs in the same cycle.
  - OVF clears only on reset.
  - A simultaneous push and pop with count between 1 and DEPTH-1 leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FULL and EMPTY are registered and derived from the count.
- FSM states: IDLE, SETUP, STROBE, HOLD, HALT.
  - IDLE: strobes low. If EMPTY=0 and DONE=0, pop on this edge: load GPOUT[7:0] and the kind register, go to SETUP. Otherwise stay in IDLE.
  - SETUP: hold for SETUP_CYCLES cycles. The exit edge raises the strobe selected by the popped KIND (GPOUT[9] for KIND=0, GPOUT[10] for KIND=1); go to STROBE.
  - STROBE: the strobe is high for exactly STROBE_CYCLES cycles. The exit edge lowers it; go to HOLD.
  - HOLD: GPOUT[7:0] is held for HOLD_CYCLES cycles. On exit, go to HALT if KIND=1 and data=8'd1; otherwise go to IDLE.
  - HALT: terminal until reset. DONE=1, strobes low, GPOUT[7:0] holds 8'd1. Pushes are still accepted into the FIFO but are never transmitted.
- Strobe and data rules:
  - Only one of GPOUT[9] and GPOUT[10] is ever high.
  - GPOUT[7:0] changes only on the pop edge, never while a strobe is high.
- Timing with defaults, for a push at edge N into an empty FIFO with the FSM in IDLE:
  - Pop at edge N+1; GPOUT[7:0] valid after N+1.
  - Strobe rises at N+2 and falls at N+4.
  - FSM is back in IDLE at N+5; the next pop is at N+6.
- Item period is 1 + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES cycles (5 with defaults).
- One IDLE cycle always separates consecutive items.
- A counter sized for the largest of SETUP_CYCLES, STROBE_CYCLES and HOLD_CYCLES reloads on each state entry.

Test Plan:
- Reset then push char 8'h41 at edge 10 → GPOUT[7:0]=8'h41 after edge 11; GPOUT[9] high over edges 12–14; GPOUT[10] stays 0; BUSY high over edges 11–15.
- Push "Hi\n" (8'h48, 8'h69, 8'h0A) back-to-back → three GPOUT[9] pulses exactly 5 cycles apart; the display prints "Hi" plus newline; data stable at every strobe rising edge.
- Push code 8'd42 then code 8'd1 → GPOUT[10] pulses with data 42, then 1. DONE=1 four cycles after the second pop. A later push of char 8'h5A produces no strobe, and EMPTY goes 0.
- Push 17 items with no pops possible (FSM held in STROBE), default depth → FULL=1 after 16 accepted, 17th dropped, OVF=1. The remaining 16 are drained in order with no loss.
- With FIFO full, push and pop in the same cycle → push rejected, OVF=1, count=15 afterwards.
- Assert RSTn low for 3 ns asynchronously while GPOUT[10] is high with 3 items queued → GPOUT=0 immediately; EMPTY=1; no strobe after reset release until a new push.
